// File: rtl/ncpu32k_icache_dm_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package ncpu32k_icache_dm_pkg;

  localparam int IC_P_LINE_DEF = 4;
  localparam int IC_P_SETS_DEF = 6;
  localparam int EXC_W         = 2;

  localparam logic [EXC_W-1:0] EXC_NONE = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_RESP,
    S_INVAL
  } ic_state_e;

endpackage

// File: rtl/ncpu32k_icache_ram.sv
// Single-port synchronous RAM, registered read port (1-cycle latency, read-old on write).
module ncpu32k_icache_ram #(
  parameter int P_DEPTH = 6,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [P_DEPTH-1:0] addr_i,
  input  logic [DW-1:0]      din_i,
  output logic [DW-1:0]      dout_o
);

  logic [DW-1:0] mem_q [2**P_DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= din_i;
      dout_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/ncpu32k_icache_dm.sv
// Direct-mapped instruction cache: one fetch in flight, word-by-word line refill,
// valid bits in flops so invalidate-all walks them one set per cycle.
module ncpu32k_icache_dm
  import ncpu32k_icache_dm_pkg::*;
#(
  parameter int CONFIG_IC_P_LINE = IC_P_LINE_DEF,
  parameter int CONFIG_IC_P_SETS = IC_P_SETS_DEF,
  parameter int CONFIG_AW        = 32,
  parameter int CONFIG_IW        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 icache_AREADY,
  input  logic                 icache_AVALID,
  input  logic [CONFIG_AW-1:0] icache_AADDR,
  input  logic [EXC_W-1:0]     icache_AEXC,
  output logic                 icache_BVALID,
  input  logic                 icache_BREADY,
  output logic [CONFIG_IW-1:0] icache_BDATA,
  output logic [EXC_W-1:0]     icache_BEXC,
  input  logic                 inv_req,
  output logic                 inv_ack,
  input  logic                 fb_ibus_AREADY,
  output logic                 fb_ibus_AVALID,
  output logic [CONFIG_AW-1:0] fb_ibus_AADDR,
  output logic [EXC_W-1:0]     fb_ibus_AEXC,
  input  logic                 fb_ibus_BVALID,
  output logic                 fb_ibus_BREADY,
  input  logic [CONFIG_IW-1:0] fb_ibus_BDATA,
  input  logic [EXC_W-1:0]     fb_ibus_BEXC
);

  localparam int OFF_W = CONFIG_IC_P_LINE - 2;
  localparam int IDX_W = CONFIG_IC_P_SETS;
  localparam int TAG_W = CONFIG_AW - CONFIG_IC_P_LINE - CONFIG_IC_P_SETS;
  localparam int LSB_I = CONFIG_IC_P_LINE;
  localparam int LSB_T = CONFIG_IC_P_LINE + CONFIG_IC_P_SETS;

  ic_state_e               state_q;
  logic [CONFIG_AW-1:0]    req_addr_q;
  logic [OFF_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        set_q;
  logic [(1<<IDX_W)-1:0]   valid_q;
  logic                    resp_vld_q;
  logic [CONFIG_IW-1:0]    bdata_q;
  logic [EXC_W-1:0]        bexc_q;
  logic                    fb_avalid_q;
  logic [CONFIG_AW-1:0]    fb_addr_q;
  logic                    inv_ack_q;

  logic [IDX_W-1:0]        a_idx, r_idx;
  logic [OFF_W-1:0]        a_off, r_off, cnt_d;
  logic [TAG_W-1:0]        r_tag, tag_dout;
  logic [IDX_W-1:0]        set_d;
  logic [CONFIG_IW-1:0]    data_dout;
  logic                    accept, lookup_go, hit, beat_ok, last_beat;
  logic                    unused_ok;

  assign a_idx = icache_AADDR[LSB_T-1:LSB_I];
  assign a_off = icache_AADDR[LSB_I-1:2];
  assign r_idx = req_addr_q[LSB_T-1:LSB_I];
  assign r_off = req_addr_q[LSB_I-1:2];
  assign r_tag = req_addr_q[CONFIG_AW-1:LSB_T];
  assign cnt_d = cnt_q + OFF_W'(1);
  assign set_d = set_q + IDX_W'(1);
  assign unused_ok = ^{icache_AADDR[1:0], req_addr_q[1:0]};

  assign icache_AREADY = ~rst & (state_q == S_IDLE) & ~inv_req;
  assign accept        = icache_AVALID & icache_AREADY;
  assign lookup_go     = accept & (icache_AEXC == EXC_NONE);
  assign hit           = (state_q == S_LOOKUP) & valid_q[r_idx] & (tag_dout == r_tag);
  assign beat_ok       = ~rst & (state_q == S_REFILL_WAIT) & fb_ibus_BVALID &
                         (fb_ibus_BEXC == EXC_NONE);
  assign last_beat     = beat_ok & (cnt_q == {OFF_W{1'b1}});

  // RAMs are addressed from the core port in IDLE, from the latched request otherwise
  ncpu32k_icache_ram #(.P_DEPTH(IDX_W), .DW(TAG_W)) u_tag_ram (
    .clk    (clk),
    .en_i   (lookup_go | last_beat),
    .we_i   (last_beat),
    .addr_i ((state_q == S_IDLE) ? a_idx : r_idx),
    .din_i  (r_tag),
    .dout_o (tag_dout)
  );

  ncpu32k_icache_ram #(.P_DEPTH(IDX_W + OFF_W), .DW(CONFIG_IW)) u_data_ram (
    .clk    (clk),
    .en_i   (lookup_go | beat_ok),
    .we_i   (beat_ok),
    .addr_i ((state_q == S_IDLE) ? {a_idx, a_off} : {r_idx, cnt_q}),
    .din_i  (fb_ibus_BDATA),
    .dout_o (data_dout)
  );

  // A hit is answered straight from the RAM output in LOOKUP; everything else from registers
  assign icache_BVALID  = ~rst & (resp_vld_q | hit);
  assign icache_BDATA   = rst ? '0 : (hit ? data_dout : bdata_q);
  assign icache_BEXC    = rst ? '0 : (hit ? EXC_NONE : bexc_q);
  assign fb_ibus_AVALID = ~rst & fb_avalid_q;
  assign fb_ibus_AADDR  = fb_addr_q;
  assign fb_ibus_AEXC   = EXC_NONE;
  assign fb_ibus_BREADY = ~rst & (state_q == S_REFILL_WAIT);
  assign inv_ack        = ~rst & inv_ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_addr_q  <= '0;
      cnt_q       <= '0;
      set_q       <= '0;
      resp_vld_q  <= 1'b0;
      bdata_q     <= '0;
      bexc_q      <= EXC_NONE;
      fb_avalid_q <= 1'b0;
      fb_addr_q   <= '0;
      inv_ack_q   <= 1'b0;
    end else begin
      inv_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inv_req) begin
            set_q   <= '0;
            state_q <= S_INVAL;
          end else if (icache_AVALID) begin
            req_addr_q <= icache_AADDR;
            if (icache_AEXC != EXC_NONE) begin
              resp_vld_q <= 1'b1;
              bexc_q     <= icache_AEXC;
              bdata_q    <= '0;
              state_q    <= S_RESP;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (icache_BREADY) begin
              state_q <= S_IDLE;
            end else begin
              resp_vld_q <= 1'b1;
              bdata_q    <= data_dout;
              bexc_q     <= EXC_NONE;
              state_q    <= S_RESP;
            end
          end else begin
            cnt_q       <= '0;
            fb_avalid_q <= 1'b1;
            fb_addr_q   <= {req_addr_q[CONFIG_AW-1:LSB_I], {LSB_I{1'b0}}};
            state_q     <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          if (fb_ibus_AREADY) begin
            fb_avalid_q <= 1'b0;
            state_q     <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (fb_ibus_BVALID) begin
            if (fb_ibus_BEXC != EXC_NONE) begin
              bexc_q     <= fb_ibus_BEXC;
              bdata_q    <= '0;
              resp_vld_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              if (cnt_q == r_off) bdata_q <= fb_ibus_BDATA;
              if (cnt_q == {OFF_W{1'b1}}) begin
                valid_q[r_idx] <= 1'b1;
                bexc_q         <= EXC_NONE;
                resp_vld_q     <= 1'b1;
                state_q        <= S_RESP;
              end else begin
                cnt_q       <= cnt_d;
                fb_addr_q   <= {req_addr_q[CONFIG_AW-1:LSB_I], cnt_d, 2'b00};
                fb_avalid_q <= 1'b1;
                state_q     <= S_REFILL_REQ;
              end
            end
          end
        end
        S_RESP: begin
          if (icache_BREADY) begin
            resp_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_INVAL: begin
          valid_q[set_q] <= 1'b0;
          set_q          <= set_d;
          if (set_q == {IDX_W{1'b1}}) begin
            inv_ack_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncpu32k_icache_dm.sv
// Directed bench for the direct-mapped icache: refill, hit, conflict miss,
// upstream and bus exceptions, backpressure, invalidate-all and reset mid-refill.
module tb_ncpu32k_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_AREADY, icache_AVALID = 1'b0;
  logic [31:0] icache_AADDR = '0;
  logic [1:0]  icache_AEXC = '0;
  logic        icache_BVALID, icache_BREADY = 1'b0;
  logic [31:0] icache_BDATA;
  logic [1:0]  icache_BEXC;
  logic        inv_req = 1'b0, inv_ack;
  logic        fb_ibus_AREADY = 1'b1, fb_ibus_AVALID;
  logic [31:0] fb_ibus_AADDR;
  logic [1:0]  fb_ibus_AEXC;
  logic        fb_ibus_BVALID = 1'b0, fb_ibus_BREADY;
  logic [31:0] fb_ibus_BDATA = '0;
  logic [1:0]  fb_ibus_BEXC = '0;

  int          total = 0, passed = 0;
  logic [31:0] req_log [$];
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  ncpu32k_icache_dm dut (
    .clk(clk), .rst(rst),
    .icache_AREADY(icache_AREADY), .icache_AVALID(icache_AVALID),
    .icache_AADDR(icache_AADDR), .icache_AEXC(icache_AEXC),
    .icache_BVALID(icache_BVALID), .icache_BREADY(icache_BREADY),
    .icache_BDATA(icache_BDATA), .icache_BEXC(icache_BEXC),
    .inv_req(inv_req), .inv_ack(inv_ack),
    .fb_ibus_AREADY(fb_ibus_AREADY), .fb_ibus_AVALID(fb_ibus_AVALID),
    .fb_ibus_AADDR(fb_ibus_AADDR), .fb_ibus_AEXC(fb_ibus_AEXC),
    .fb_ibus_BVALID(fb_ibus_BVALID), .fb_ibus_BREADY(fb_ibus_BREADY),
    .fb_ibus_BDATA(fb_ibus_BDATA), .fb_ibus_BEXC(fb_ibus_BEXC)
  );

  // Memory model: one-cycle response, word = DEAD_<addr[15:0]>, error on err_addr
  always @(posedge clk) begin
    if (rst) begin
      fb_ibus_BVALID <= 1'b0;
    end else begin
      if (fb_ibus_BVALID && fb_ibus_BREADY) fb_ibus_BVALID <= 1'b0;
      if (fb_ibus_AVALID && fb_ibus_AREADY) begin
        req_log.push_back(fb_ibus_AADDR);
        fb_ibus_BVALID <= 1'b1;
        fb_ibus_BDATA  <= 32'hDEAD_0000 | {16'h0, fb_ibus_AADDR[15:0]};
        fb_ibus_BEXC   <= (fb_ibus_AADDR == err_addr) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one fetch, hold BREADY low for 'hold' cycles (checking stability), then handshake.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [1:0] e,
                       input int hold, input logic [31:0] exp_d,
                       output logic [31:0] d, output logic [1:0] x, output int lat);
    int n;
    @(negedge clk);
    icache_AVALID = 1'b1; icache_AADDR = a; icache_AEXC = e; icache_BREADY = 1'b0;
    n = 0;
    while (!icache_AREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({tag, "_accept_timeout"}, 32'(n), 32'd0);
    @(negedge clk);
    icache_AVALID = 1'b0; icache_AEXC = 2'b00;
    lat = 1;
    while (!icache_BVALID && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) chk({tag, "_resp_timeout"}, 32'(lat), 32'd0);
    d = icache_BDATA; x = icache_BEXC;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_bvalid"}, 32'(icache_BVALID), 32'd1);
      chk({tag, "_hold_bdata"}, icache_BDATA, exp_d);
    end
    icache_BREADY = 1'b1;
    @(negedge clk);
    icache_BREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  x;
    int          lat, n0, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_aready", 32'(icache_AREADY), 32'd0);
    chk("rst_bvalid", 32'(icache_BVALID), 32'd0);
    chk("rst_bdata", icache_BDATA, 32'd0);
    chk("rst_bexc", 32'(icache_BEXC), 32'd0);
    chk("rst_fb_avalid", 32'(fb_ibus_AVALID), 32'd0);
    chk("rst_fb_bready", 32'(fb_ibus_BREADY), 32'd0);
    chk("rst_inv_ack", 32'(inv_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("aready_after_rst", 32'(icache_AREADY), 32'd1);

    // Cold miss on 0x100: whole line refilled in ascending order
    n0 = req_log.size();
    fetch("miss100", 32'h100, 2'b00, 0, 32'hDEAD0100, d, x, lat);
    chk("miss100_nreq", 32'(req_log.size() - n0), 32'd4);
    if (req_log.size() >= n0 + 4) begin
      chk("miss100_a0", req_log[n0],   32'h100);
      chk("miss100_a1", req_log[n0+1], 32'h104);
      chk("miss100_a2", req_log[n0+2], 32'h108);
      chk("miss100_a3", req_log[n0+3], 32'h10C);
    end
    chk("miss100_data", d, 32'hDEAD0100);
    chk("miss100_exc", 32'(x), 32'd0);

    // Hit on another word of the same line
    n0 = req_log.size();
    fetch("hit104", 32'h104, 2'b00, 0, 32'hDEAD0104, d, x, lat);
    chk("hit104_lat", 32'(lat), 32'd1);
    chk("hit104_nreq", 32'(req_log.size() - n0), 32'd0);
    chk("hit104_data", d, 32'hDEAD0104);
    chk("hit104_exc", 32'(x), 32'd0);

    // Conflict: 0x500 evicts 0x100
    n0 = req_log.size();
    fetch("miss500", 32'h508, 2'b00, 0, 32'hDEAD0508, d, x, lat);
    chk("miss500_nreq", 32'(req_log.size() - n0), 32'd4);
    if (req_log.size() >= n0 + 4) begin
      chk("miss500_a0", req_log[n0],   32'h500);
      chk("miss500_a3", req_log[n0+3], 32'h50C);
    end
    chk("miss500_data", d, 32'hDEAD0508);
    n0 = req_log.size();
    fetch("remiss100", 32'h10C, 2'b00, 0, 32'hDEAD010C, d, x, lat);
    chk("remiss100_nreq", 32'(req_log.size() - n0), 32'd4);
    chk("remiss100_data", d, 32'hDEAD010C);

    // Upstream exception bypasses the cache entirely
    n0 = req_log.size();
    fetch("aexc", 32'h200, 2'b01, 0, 32'h0, d, x, lat);
    chk("aexc_lat", 32'(lat), 32'd1);
    chk("aexc_exc", 32'(x), 32'd1);
    chk("aexc_data", d, 32'd0);
    chk("aexc_nreq", 32'(req_log.size() - n0), 32'd0);

    // Bus error on third refill word aborts the line
    err_addr = 32'h308;
    n0 = req_log.size();
    fetch("berr", 32'h304, 2'b00, 0, 32'h0, d, x, lat);
    chk("berr_exc", 32'(x), 32'd2);
    chk("berr_nreq", 32'(req_log.size() - n0), 32'd3);
    err_addr = 32'hFFFF_FFFF;
    n0 = req_log.size();
    fetch("after_berr", 32'h304, 2'b00, 0, 32'hDEAD0304, d, x, lat);
    chk("after_berr_nreq", 32'(req_log.size() - n0), 32'd4);
    chk("after_berr_data", d, 32'hDEAD0304);
    chk("after_berr_exc", 32'(x), 32'd0);

    // Backpressure on a hit: response must stay put for 5 cycles
    n0 = req_log.size();
    fetch("hold", 32'h300, 2'b00, 5, 32'hDEAD0300, d, x, lat);
    chk("hold_lat", 32'(lat), 32'd1);
    chk("hold_data", d, 32'hDEAD0300);
    chk("hold_nreq", 32'(req_log.size() - n0), 32'd0);

    // Invalidate all: 64 clearing cycles, then a one-cycle ack
    @(negedge clk);
    inv_req = 1'b1;
    #1 chk("inv_aready_low", 32'(icache_AREADY), 32'd0);
    n = 0;
    @(negedge clk);
    inv_req = 1'b0;
    n = 1;
    while (!inv_ack && n < 200) begin @(negedge clk); n++; end
    chk("inv_ack_cycles", 32'(n), 32'd65);
    @(negedge clk);
    chk("inv_ack_pulse", 32'(inv_ack), 32'd0);
    n0 = req_log.size();
    fetch("after_inv", 32'h300, 2'b00, 0, 32'hDEAD0300, d, x, lat);
    chk("after_inv_nreq", 32'(req_log.size() - n0), 32'd4);
    chk("after_inv_data", d, 32'hDEAD0300);

    // Reset during a refill abandons it
    @(negedge clk);
    n0 = req_log.size();
    icache_AVALID = 1'b1; icache_AADDR = 32'h704;
    @(negedge clk);
    icache_AVALID = 1'b0;
    n = 0;
    while (req_log.size() == n0 && n < 50) begin @(negedge clk); n++; end
    chk("midrst_req_seen", 32'(req_log.size() - n0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_bvalid", 32'(icache_BVALID), 32'd0);
    chk("midrst_fb_bready", 32'(fb_ibus_BREADY), 32'd0);
    chk("midrst_fb_avalid", 32'(fb_ibus_AVALID), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n0 = req_log.size();
    fetch("after_midrst", 32'h704, 2'b00, 0, 32'hDEAD0704, d, x, lat);
    chk("after_midrst_nreq", 32'(req_log.size() - n0), 32'd4);
    chk("after_midrst_data", d, 32'hDEAD0704);
    chk("after_midrst_exc", 32'(x), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ncpu32k_icache_dm.md
NCPU32K_ICACHE_DM -- requirements
Module: ncpu32k_icache_dm

Interface
REQ-001 SHALL have parameter CONFIG_IC_P_LINE, default 4, log2 bytes per line (16 B, 4 words).
REQ-002 SHALL have parameter CONFIG_IC_P_SETS, default 6, log2 number of sets (64).
REQ-003 SHALL have parameter CONFIG_AW, default 32, address width; parameter CONFIG_IW, default 32, instruction width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- icache_AREADY  out  1  core request accepted when high with AVALID.
- icache_AVALID  in  1  core fetch request valid.
- icache_AADDR  in  AW  fetch byte address; bits [1:0] are ignored.
- icache_AEXC  in  2  upstream exception (MMU); nonzero means bypass.
- icache_BVALID  out  1  response valid.
- icache_BREADY  in  1  core accepts response.
- icache_BDATA  out  IW  instruction word.
- icache_BEXC  out  2  response exception code.
- inv_req  in  1  invalidate-all request.
- inv_ack  out  1  one-cycle pulse when invalidation is complete.
- fb_ibus_AREADY / AVALID / AADDR / AEXC  in/out/out/out  1/1/AW/2  refill request channel; AEXC is driven to 0.
- fb_ibus_BVALID / BREADY / BDATA / BEXC  in/out/in/in  1/1/IW/2  refill response channel.

Function
REQ-005 SHALL be direct-mapped: offset = AADDR[P_LINE-1:2], index = AADDR[P_LINE+P_SETS-1:P_LINE], tag = AADDR[AW-1:P_LINE+P_SETS].
REQ-006 SHALL implement FSM states IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP and INVAL.
REQ-007 SHALL assert icache_AREADY only in IDLE with inv_req low, allowing one request in flight.
REQ-008 On acceptance in cycle T, SHALL issue tag and data RAM reads; the FSM SHALL enter LOOKUP in T+1.
REQ-009 On a LOOKUP hit (valid and tag equal), SHALL assert BVALID in T+1 with the RAM word and BEXC=0.
REQ-010 SHALL hold BVALID, BDATA and BEXC stable until BREADY is high; it SHALL return to IDLE in the cycle after the handshake.
REQ-011 If AEXC is nonzero at acceptance, SHALL skip lookup and bus activity and present BVALID in T+1 with BEXC=AEXC and BDATA=0.
REQ-012 On a miss, SHALL refill the whole line by issuing 2^(P_LINE-2) word requests in ascending order from the line base.
- Exactly one bus request is outstanding at a time (REFILL_REQ -> REFILL_WAIT).
- fb_ibus_BREADY is high only in REFILL_WAIT.
REQ-013 SHALL write each refill word into the data RAM as it arrives and capture the requested word into the response register.
REQ-014 SHALL write the tag and set the valid bit only after the last refill word, then enter RESP.
REQ-015 If any refill response has nonzero fb_ibus_BEXC, SHALL abort the refill, leave the valid bit clear and respond with BEXC=fb_ibus_BEXC.
REQ-016 SHALL keep fb_ibus_AVALID high and AADDR stable until fb_ibus_AREADY is sampled high.
REQ-017 SHALL sample inv_req only in IDLE, where it takes priority over a simultaneous AVALID.
REQ-018 In INVAL, SHALL clear one valid bit per cycle for sets 0 through 2^P_SETS-1, then pulse inv_ack for one cycle and return to IDLE.
REQ-019 SHALL hold valid bits in flops; the set index counter SHALL wrap at 2^P_SETS-1 without an overflow bit.

Reset
REQ-020 While rst is high, SHALL force: state=IDLE, all valid bits=0, icache_AREADY=0, icache_BVALID=0, BDATA=0, BEXC=0, fb_ibus_AVALID=0, fb_ibus_BREADY=0, inv_ack=0.
REQ-021 Reset asserted mid-refill SHALL abandon the refill without marking the line valid; responses arriving after reset SHALL be ignored.
REQ-022 SHALL drive icache_AREADY high in the first cycle after rst deasserts.

Structure
REQ-023 SHALL take default line/set sizes and exception code constants from the shared header ncpu32k_config.h.
REQ-024 SHALL instantiate the tag and data arrays as sub-module ncpu32k_icache_ram, a parametrised single-port synchronous RAM with 1-cycle read latency.
REQ-025 SHALL derive all widths from parameters, with no hardcoded 16 B or 64 sets.

Verification
REQ-026 Reset, then fetch 0x100 -> 4 bus requests to 0x100, 0x104, 0x108, 0x10C; BDATA equals the word from 0x100; BEXC=0.
REQ-027 Repeat fetch of 0x104 after REQ-026 -> BVALID one cycle after acceptance, no bus activity, correct word.
REQ-028 Fetch 0x500 (same index as 0x100, different tag) -> refill of 0x500-0x50C, then fetch 0x100 misses again.
REQ-029 Fetch with AEXC=2'b01 -> BVALID in T+1, BEXC=2'b01, fb_ibus_AVALID stays 0.
REQ-030 Refill with the third word returning BEXC=2'b10 -> response BEXC=2'b10, and the same address misses on the next fetch.
REQ-031 Hold BREADY low for 5 cycles on a hit -> BVALID/BDATA stable; inv_req -> inv_ack after 64 cycles, and a prior hit address now misses.
